mac_rx: RTL and testbench

Receive-side counterpart of the RMII transmit MAC: deserialises RMII dibits into frames, strips preamble/SFD, checks CRC-32 and destination address, and streams the frame body as 32-bit little-endian words plus one per-frame status pulse. Sits between the RMII pin synchroniser and the command/config frame consumer, in the same `clk` domain as the transmit MAC and DAQ.

---
 rtl/mac_rx.sv | 237 +++++++++++++++++++++++
 tb/tb_mac_rx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx.sv
// RMII receive MAC: dibits -> bytes -> 32-bit little-endian words, with CRC-32,
// destination-address and length checks reported on a per-frame done pulse.
module mac_rx #(
    parameter int unsigned MAC_PACKET_BITS = 9,
    parameter int unsigned MIN_LEN         = 64,
    parameter int unsigned MAX_LEN         = 1522
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_strobe,
    input  logic                       rx0,
    input  logic                       rx1,
    input  logic                       crs_dv,
    input  logic [47:0]                my_mac,
    output logic [31:0]                rxo_data,
    output logic                       rxo_valid,
    output logic                       rxo_done,
    output logic [10:0]                rxo_len,
    output logic [MAC_PACKET_BITS-1:0] rxo_words,
    output logic                       rxo_crc_ok,
    output logic                       rxo_mac_ok,
    output logic                       rxo_err
);

    localparam logic [10:0] LenMin     = 11'(MIN_LEN);
    localparam logic [10:0] LenMax     = 11'(MAX_LEN);
    localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        StSync, StIdle, StPre, StData, StDrop, StDropSt, StFin
    } state_e;

    state_e                     state_q, state_d;
    logic [5:0]                 sh_q, sh_d;
    logic [1:0]                 dcnt_q, dcnt_d;
    logic [31:0]                crc_q, crc_d;
    logic [10:0]                len_q, len_d;
    logic [31:0]                word_q, word_d;
    logic [MAC_PACKET_BITS-1:0] words_q, words_d, words_inc;
    logic                       match_q, match_d;
    logic                       bcast_q, bcast_d;
    logic [31:0]                data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       done_q, done_d;
    logic [10:0]                olen_q, olen_d;
    logic [MAC_PACKET_BITS-1:0] owords_q, owords_d;
    logic                       crc_ok_q, crc_ok_d;
    logic                       mac_ok_q, mac_ok_d;
    logic                       err_q, err_d;

    logic [7:0] byte_w;
    logic [7:0] mac_byte;
    logic       latch_st;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Dibits arrive LSB first, so each new dibit lands on top of the byte.
    assign byte_w    = {rx1, rx0, sh_q};
    assign words_inc = (&words_q) ? words_q : words_q + MAC_PACKET_BITS'(1);

    always_comb begin
        case (len_q[2:0])
            3'd0:    mac_byte = my_mac[47:40];
            3'd1:    mac_byte = my_mac[39:32];
            3'd2:    mac_byte = my_mac[31:24];
            3'd3:    mac_byte = my_mac[23:16];
            3'd4:    mac_byte = my_mac[15:8];
            3'd5:    mac_byte = my_mac[7:0];
            default: mac_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        dcnt_d   = dcnt_q;
        crc_d    = crc_q;
        len_d    = len_q;
        word_d   = word_q;
        words_d  = words_q;
        match_d  = match_q;
        bcast_d  = bcast_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        olen_d   = olen_q;
        owords_d = owords_q;
        crc_ok_d = crc_ok_q;
        mac_ok_d = mac_ok_q;
        err_d    = err_q;
        latch_st = 1'b0;

        case (state_q)
            StSync: if (rx_strobe && !crs_dv) state_d = StIdle;
            StIdle: if (rx_strobe && crs_dv) state_d = StPre;
            StPre: begin
                if (rx_strobe) begin
                    if (!crs_dv) begin
                        state_d = StDrop;
                    end else if ({rx1, rx0} == 2'b11) begin
                        state_d = StData;
                        sh_d    = 6'h0;
                        dcnt_d  = 2'd0;
                        crc_d   = 32'hFFFFFFFF;
                        len_d   = 11'd0;
                        word_d  = 32'h0;
                        words_d = '0;
                        match_d = 1'b1;
                        bcast_d = 1'b1;
                    end else if ({rx1, rx0} != 2'b01) begin
                        state_d = StDrop;
                    end
                end
            end
            StData: begin
                if (rx_strobe) begin
                    if (!crs_dv) begin
                        if (len_q[1:0] != 2'd0) begin
                            data_d  = word_q;
                            valid_d = 1'b1;
                            words_d = words_inc;
                            state_d = StFin;
                        end else begin
                            latch_st = 1'b1;
                            state_d  = StIdle;
                        end
                    end else begin
                        sh_d   = byte_w[7:2];
                        dcnt_d = dcnt_q + 2'd1;
                        if (dcnt_q == 2'd3) begin
                            len_d = len_q + 11'd1;
                            crc_d = crc_byte(crc_q, byte_w);
                            if (len_q < 11'd6) begin
                                match_d = match_q & (byte_w == mac_byte);
                                bcast_d = bcast_q & (byte_w == 8'hFF);
                            end
                            if (len_q == LenMax) begin
                                state_d = StDropSt;
                            end else begin
                                unique case (len_q[1:0])
                                    2'd0: word_d = {24'h0, byte_w};
                                    2'd1: word_d[15:8] = byte_w;
                                    2'd2: word_d[23:16] = byte_w;
                                    default: begin
                                        word_d[31:24] = byte_w;
                                        data_d        = {byte_w, word_q[23:0]};
                                        valid_d       = 1'b1;
                                        words_d       = words_inc;
                                    end
                                endcase
                            end
                        end
                    end
                end
            end
            StFin: begin
                latch_st = 1'b1;
                state_d  = StIdle;
            end
            StDropSt: begin
                if (rx_strobe && !crs_dv) begin
                    latch_st = 1'b1;
                    state_d  = StIdle;
                end
            end
            StDrop: if (rx_strobe && !crs_dv) state_d = StIdle;
            default: state_d = StSync;
        endcase

        // An overlength frame leaves len_q at MAX_LEN+1, which also forces crc_ok low.
        if (latch_st) begin
            done_d   = 1'b1;
            olen_d   = len_q;
            owords_d = words_q;
            crc_ok_d = (crc_q == CrcResidue) && (len_q <= LenMax);
            mac_ok_d = match_q | bcast_q;
            err_d    = (dcnt_q != 2'd0) || (len_q < LenMin) || (len_q > LenMax);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StSync;
            sh_q     <= 6'h0;
            dcnt_q   <= 2'd0;
            crc_q    <= 32'h0;
            len_q    <= 11'd0;
            word_q   <= 32'h0;
            words_q  <= '0;
            match_q  <= 1'b0;
            bcast_q  <= 1'b0;
            data_q   <= 32'h0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            olen_q   <= 11'd0;
            owords_q <= '0;
            crc_ok_q <= 1'b0;
            mac_ok_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            dcnt_q   <= dcnt_d;
            crc_q    <= crc_d;
            len_q    <= len_d;
            word_q   <= word_d;
            words_q  <= words_d;
            match_q  <= match_d;
            bcast_q  <= bcast_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            olen_q   <= olen_d;
            owords_q <= owords_d;
            crc_ok_q <= crc_ok_d;
            mac_ok_q <= mac_ok_d;
            err_q    <= err_d;
        end
    end

    assign rxo_data   = data_q;
    assign rxo_valid  = valid_q;
    assign rxo_done   = done_q;
    assign rxo_len    = olen_q;
    assign rxo_words  = owords_q;
    assign rxo_crc_ok = crc_ok_q;
    assign rxo_mac_ok = mac_ok_q;
    assign rxo_err    = err_q;

endmodule

// File: tb/tb_mac_rx.sv
// Directed bench for mac_rx: builds frames with a reference FCS, drives them as
// RMII dibits and checks word stream, status flags and done timing.
module tb_mac_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_strobe;
    logic        rx0;
    logic        rx1;
    logic        crs_dv;
    logic [47:0] my_mac;
    logic [31:0] rxo_data;
    logic        rxo_valid;
    logic        rxo_done;
    logic [10:0] rxo_len;
    logic [8:0]  rxo_words;
    logic        rxo_crc_ok;
    logic        rxo_mac_ok;
    logic        rxo_err;

    mac_rx #(
        .MAC_PACKET_BITS(9),
        .MIN_LEN        (64),
        .MAX_LEN        (1522)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_strobe (rx_strobe),
        .rx0       (rx0),
        .rx1       (rx1),
        .crs_dv    (crs_dv),
        .my_mac    (my_mac),
        .rxo_data  (rxo_data),
        .rxo_valid (rxo_valid),
        .rxo_done  (rxo_done),
        .rxo_len   (rxo_len),
        .rxo_words (rxo_words),
        .rxo_crc_ok(rxo_crc_ok),
        .rxo_mac_ok(rxo_mac_ok),
        .rxo_err   (rxo_err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          last_strobe_cyc = 0;
    int          n_valid = 0;
    int          n_done  = 0;
    int          done_delta = 0;
    logic [31:0] first_data = 32'h0;
    logic [31:0] last_data  = 32'h0;
    logic [7:0]  frame [0:1599];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rxo_valid) begin
            if (n_valid == 0) first_data = rxo_data;
            last_data = rxo_data;
            n_valid++;
        end
        if (rxo_done) begin
            n_done++;
            done_delta = cyc - last_strobe_cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic add_fcs(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) c = crc_upd(c, frame[i]);
        c = ~c;
        frame[n-4] = c[7:0];
        frame[n-3] = c[15:8];
        frame[n-2] = c[23:16];
        frame[n-1] = c[31:24];
    endtask

    task automatic build_frame(input logic [47:0] dst, input int n);
        for (int i = 0; i < 6; i++) frame[i] = dst[47-8*i -: 8];
        for (int i = 6; i < 12; i++) frame[i] = 8'(i == 11 ? 1 : (i == 6 ? 2 : 0));
        for (int i = 12; i < n; i++) frame[i] = 8'(i) ^ 8'h5A;
        add_fcs(n);
    endtask

    // Pick the last payload byte so the final FCS byte on the wire equals target.
    task automatic tune_last(input int n, input logic [7:0] target);
        for (int v = 0; v < 256; v++) begin
            frame[n-5] = 8'(v);
            add_fcs(n);
            if (frame[n-1] == target) break;
        end
    endtask

    task automatic send_dibit(input logic [1:0] d, input logic dv);
        @(negedge clk);
        rx_strobe = 1'b1;
        rx0 = d[0];
        rx1 = d[1];
        crs_dv = dv;
        last_strobe_cyc = cyc;
        @(negedge clk);
        rx_strobe = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) send_dibit(b[2*k +: 2], 1'b1);
    endtask

    task automatic send_pre();
        for (int i = 0; i < 31; i++) send_dibit(2'b01, 1'b1);
        send_dibit(2'b11, 1'b1);
    endtask

    task automatic send_frame(input int n, input int extra);
        send_pre();
        for (int i = 0; i < n; i++) send_byte(frame[i]);
        for (int i = 0; i < extra; i++) send_dibit(2'b10, 1'b1);
        send_dibit(2'b00, 1'b0);
    endtask

    task automatic clr();
        n_valid = 0;
        n_done  = 0;
    endtask

    task automatic check_frame(input string tag, input int ev, input int elen, input int ewords,
                               input logic ecrc, input logic emac, input logic eerr,
                               input int edelta);
        repeat (6) @(posedge clk);
        #2;
        chk({tag, ".done_cnt"}, n_done, 1);
        chk({tag, ".valid_cnt"}, n_valid, ev);
        chk({tag, ".len"}, {21'h0, rxo_len}, elen);
        chk({tag, ".words"}, {23'h0, rxo_words}, ewords);
        chk({tag, ".crc_ok"}, {31'h0, rxo_crc_ok}, {31'h0, ecrc});
        chk({tag, ".mac_ok"}, {31'h0, rxo_mac_ok}, {31'h0, emac});
        chk({tag, ".err"}, {31'h0, rxo_err}, {31'h0, eerr});
        chk({tag, ".done_delay"}, done_delta, edelta);
    endtask

    initial begin
        rst       = 1'b1;
        rx_strobe = 1'b0;
        rx0       = 1'b0;
        rx1       = 1'b0;
        crs_dv    = 1'b0;
        my_mac    = 48'h123456789abc;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.data", rxo_data, 32'h0);
        chk("reset.pulses", {30'h0, rxo_valid, rxo_done}, 32'h0);
        chk("reset.len_words", {12'h0, rxo_len, rxo_words}, 32'h0);
        chk("reset.flags", {29'h0, rxo_crc_ok, rxo_mac_ok, rxo_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        send_dibit(2'b00, 1'b0);
        send_dibit(2'b00, 1'b0);

        build_frame(48'h123456789abc, 64);
        clr();
        send_frame(64, 0);
        check_frame("good64", 16, 64, 16, 1'b1, 1'b1, 1'b0, 1);
        chk("good64.first_word", first_data, 32'h78563412);

        build_frame(48'hffffffffffff, 65);
        tune_last(65, 8'hA5);
        clr();
        send_frame(65, 0);
        check_frame("bcast65", 17, 65, 17, 1'b1, 1'b1, 1'b0, 2);
        chk("bcast65.last_word", last_data, 32'h000000A5);

        build_frame(48'h123456789abc, 64);
        frame[20] = frame[20] ^ 8'h10;
        clr();
        send_frame(64, 0);
        check_frame("bitflip", 16, 64, 16, 1'b0, 1'b1, 1'b0, 1);

        build_frame(48'h665544332211, 64);
        clr();
        send_frame(64, 0);
        check_frame("other_dst", 16, 64, 16, 1'b1, 1'b0, 1'b0, 1);

        clr();
        for (int i = 0; i < 5; i++) send_dibit(2'b01, 1'b1);
        send_dibit(2'b10, 1'b1);
        for (int i = 0; i < 2000; i++) send_dibit(2'($urandom_range(3, 0)), 1'b1);
        send_dibit(2'b00, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        chk("badpre.valid_cnt", n_valid, 0);
        chk("badpre.done_cnt", n_done, 0);

        build_frame(48'h123456789abc, 64);
        clr();
        send_frame(64, 0);
        check_frame("after_badpre", 16, 64, 16, 1'b1, 1'b1, 1'b0, 1);

        build_frame(48'h123456789abc, 1600);
        clr();
        send_frame(1600, 0);
        check_frame("long1600", 380, 1523, 380, 1'b0, 1'b1, 1'b1, 1);

        build_frame(48'h123456789abc, 60);
        clr();
        send_frame(60, 0);
        check_frame("short60", 15, 60, 15, 1'b1, 1'b1, 1'b1, 1);

        build_frame(48'h123456789abc, 64);
        clr();
        send_frame(64, 2);
        check_frame("dangling", 16, 64, 16, 1'b1, 1'b1, 1'b1, 1);

        // Reset at byte 30, coinciding with a strobe.
        clr();
        send_pre();
        for (int i = 0; i < 30; i++) send_byte(frame[i]);
        @(negedge clk);
        rst = 1'b1;
        rx_strobe = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        crs_dv = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst.data", rxo_data, 32'h0);
        chk("midrst.pulses", {30'h0, rxo_valid, rxo_done}, 32'h0);
        chk("midrst.len_words", {12'h0, rxo_len, rxo_words}, 32'h0);
        chk("midrst.flags", {29'h0, rxo_crc_ok, rxo_mac_ok, rxo_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rx_strobe = 1'b0;
        for (int i = 30; i < 64; i++) send_byte(frame[i]);
        send_dibit(2'b00, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        chk("midrst.done_cnt", n_done, 0);
        chk("midrst.valid_cnt", n_valid, 7);

        clr();
        send_frame(64, 0);
        send_frame(64, 0);
        repeat (6) @(posedge clk);
        #2;
        chk("b2b.done_cnt", n_done, 2);
        chk("b2b.valid_cnt", n_valid, 32);
        chk("b2b.len", {21'h0, rxo_len}, 64);
        chk("b2b.crc_ok", {31'h0, rxo_crc_ok}, 1);
        chk("b2b.err", {31'h0, rxo_err}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
